// File: rtl/return_address_stack.sv
// Return-address stack for the fetch stage: calls push, returns pop, and a FIFO of
// {ti, cnt} checkpoints restores the speculative stack pointers on a branch flush.
module return_address_stack #(
  parameter int RAS_DEPTH        = 8,
  parameter int CHECKPOINT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        flush,
  output logic [31:0] addr,
  output logic        valid
);

  localparam int TI_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int CP_W  = $clog2(CHECKPOINT_DEPTH);
  localparam int CPC_W = $clog2(CHECKPOINT_DEPTH + 1);

  logic [31:0]           stack [RAS_DEPTH];
  logic [TI_W-1:0]       ti;
  logic [CNT_W-1:0]      cnt;

  logic [TI_W+CNT_W-1:0] cp_mem [CHECKPOINT_DEPTH];
  logic [CP_W-1:0]       cp_rd, cp_wr, head_idx;
  logic [CPC_W-1:0]      cp_cnt;

  logic                  retire_deq, cp_full, enq, restore;
  logic [TI_W-1:0]       rs_ti;
  logic [CNT_W-1:0]      rs_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  assign addr  = stack[ti];
  assign valid = (cnt != '0);

  // A retire in the flush cycle retires first, so the restore point is the entry after the head.
  always_comb begin
    retire_deq      = branch_retired && (cp_cnt != '0);
    cp_full         = (cp_cnt == CPC_W'(CHECKPOINT_DEPTH));
    enq             = branch_fetched && !flush && (!cp_full || retire_deq);
    head_idx        = cp_rd + CP_W'(retire_deq);
    restore         = flush && ((cp_cnt - CPC_W'(retire_deq)) != '0);
    {rs_ti, rs_cnt} = cp_mem[head_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ti  <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (flush) begin
      if (restore) begin
        ti  <= rs_ti;
        cnt <= rs_cnt;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          ti                    <= ti + TI_W'(1);
          stack[ti + TI_W'(1)]  <= new_addr;
          cnt                   <= sat_inc(cnt);
        end
        2'b01: begin
          if (cnt != '0) ti <= ti - TI_W'(1);
          cnt <= sat_dec(cnt);
        end
        2'b11: begin
          stack[ti] <= new_addr;
          if (cnt == '0) cnt <= CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cp_rd  <= '0;
      cp_wr  <= '0;
      cp_cnt <= '0;
    end else if (flush) begin
      cp_rd  <= '0;
      cp_wr  <= '0;
      cp_cnt <= '0;
    end else begin
      if (retire_deq) cp_rd <= cp_rd + CP_W'(1);
      if (enq)        cp_wr <= cp_wr + CP_W'(1);
      cp_cnt <= cp_cnt + CPC_W'(enq) - CPC_W'(retire_deq);
    end
  end

  // Checkpoint payload is only read while the FIFO holds it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) cp_mem[cp_wr] <= {ti, cnt};
  end

  a_no_cp_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(branch_fetched && !flush && cp_full && !retire_deq));

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stack and checkpoint queue.
module tb_return_address_stack;

  localparam int RD = 8;
  localparam int CD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, branch_fetched, branch_retired, flush;
  logic [31:0] new_addr;
  logic [31:0] addr;
  logic        valid;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {int ti; int cnt;} cp_t;
  logic [31:0] m_stk [RD];
  int          m_ti, m_cnt;
  cp_t         m_q [$];

  return_address_stack #(.RAS_DEPTH(RD), .CHECKPOINT_DEPTH(CD)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
    .branch_fetched(branch_fetched), .branch_retired(branch_retired),
    .flush(flush), .addr(addr), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < RD; i++) m_stk[i] = '0;
    m_ti  = 0;
    m_cnt = 0;
    m_q.delete();
  endfunction

  function automatic void m_step(bit p, bit po, logic [31:0] a, bit bf, bit br, bit f);
    bit deq = br && (m_q.size() > 0);
    int ti0 = m_ti;
    int c0  = m_cnt;
    if (f) begin
      if (deq) void'(m_q.pop_front());
      if (m_q.size() > 0) begin
        m_ti  = m_q[0].ti;
        m_cnt = m_q[0].cnt;
      end
      m_q.delete();
    end else begin
      if (deq) void'(m_q.pop_front());
      if (bf && m_q.size() < CD) m_q.push_back('{ti0, c0});
      if (p && !po) begin
        m_ti        = (ti0 + 1) % RD;
        m_stk[m_ti] = a;
        m_cnt       = (c0 + 1 > RD) ? RD : c0 + 1;
      end else if (po && !p) begin
        if (c0 > 0) begin
          m_ti  = (ti0 + RD - 1) % RD;
          m_cnt = c0 - 1;
        end
      end else if (p && po) begin
        m_stk[ti0] = a;
        m_cnt      = (c0 < 1) ? 1 : c0;
      end
    end
  endfunction

  // One clock cycle: drive at negedge, check the combinational read, then the post-edge state.
  task automatic cyc(input bit p, input bit po, input logic [31:0] a,
                     input bit bf, input bit br, input bit f);
    @(negedge clk);
    push = p; pop = po; new_addr = a;
    branch_fetched = bf; branch_retired = br; flush = f;
    #1;
    check("pre_addr", addr, m_stk[m_ti]);
    m_step(p, po, a, bf, br, f);
    @(posedge clk);
    #1;
    check("addr", addr, m_stk[m_ti]);
    check("valid", {31'b0, valid}, {31'b0, m_cnt != 0});
  endtask

  task automatic idle_inputs();
    push = 0; pop = 0; new_addr = '0;
    branch_fetched = 0; branch_retired = 0; flush = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_addr", addr, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic push/pop
    cyc(1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0);
    check("push3_addr", addr, 32'h300);
    check("push3_valid", {31'b0, valid}, 32'h1);
    cyc(0, 1, '0, 0, 0, 0);
    check("pop1_addr", addr, 32'h200);
    cyc(0, 1, '0, 0, 0, 0);
    check("pop2_addr", addr, 32'h100);
    cyc(0, 1, '0, 0, 0, 0);
    check("pop3_valid", {31'b0, valid}, 32'h0);

    // Overflow wrap
    for (int k = 1; k <= 9; k++) cyc(1, 0, 32'(k * 16), 0, 0, 0);
    check("ovf_top", addr, 32'h90);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, '0, 0, 0, 0);
      check("ovf_pop_addr", addr, 32'(32'h90 - k * 16));
    end
    cyc(0, 1, '0, 0, 0, 0);
    check("ovf_empty_valid", {31'b0, valid}, 32'h0);
    cyc(0, 1, '0, 0, 0, 0);
    check("underflow_valid", {31'b0, valid}, 32'h0);
    check("underflow_addr", addr, 32'h90);

    // Coroutine jump
    cyc(1, 0, 32'h40, 0, 0, 0);
    cyc(1, 1, 32'h44, 0, 0, 0);
    check("coro_addr", addr, 32'h44);
    cyc(0, 1, '0, 0, 0, 0);
    check("coro_cnt1_valid", {31'b0, valid}, 32'h0);

    // Flush restore
    cyc(1, 0, 32'hA0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0);
    cyc(1, 0, 32'hB0, 0, 0, 0);
    cyc(1, 0, 32'hC0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("flush_restore_addr", addr, 32'hA0);
    cyc(0, 1, '0, 0, 0, 0);
    check("flush_restore_cnt1", {31'b0, valid}, 32'h0);

    // Retired checkpoint means no restore
    cyc(1, 0, 32'hE0, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(1, 0, 32'hD0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("retired_noflush_addr", addr, 32'hD0);
    cyc(0, 1, '0, 0, 0, 0);
    check("retired_pop_addr", addr, 32'hE0);
    cyc(0, 1, '0, 0, 0, 0);
    check("retired_empty", {31'b0, valid}, 32'h0);

    // Asynchronous reset with live state and checkpoints
    cyc(1, 0, 32'h501, 1, 0, 0);
    cyc(1, 0, 32'h502, 0, 0, 0);
    cyc(1, 0, 32'h503, 1, 0, 0);
    cyc(1, 0, 32'h504, 1, 0, 0);
    cyc(1, 0, 32'h505, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    m_reset();
    check("async_rst_addr", addr, 32'h0);
    check("async_rst_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, '0, 0, 0, 1);
    check("post_rst_flush_valid", {31'b0, valid}, 32'h0);
    check("post_rst_flush_addr", addr, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit p, po, bf, br, f;
      p  = ($urandom_range(0, 99) < 45);
      po = ($urandom_range(0, 99) < 40);
      br = ($urandom_range(0, 99) < 20);
      bf = ($urandom_range(0, 99) < 25) && (m_q.size() < CD);
      f  = ($urandom_range(0, 99) < 6);
      cyc(p, po, $urandom, bf, br, f);
    end

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
